sram_scr_init: RTL

Request-side initiator for the scrambled single-port SRAM wrapper. After a software or power-up trigger it walks every word address and writes pseudo-random filler through the RAM's req/gnt interface, so that no location is read before it has been written under the current key. It then hands the RAM port to the host as a transparent pass-through. It sits between the host bus adapter and the scrambled RAM instance.

---
 rtl/sram_scr_init.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sram_scr_init.sv
// sram_scr_init
//   Request-side initiator for the scrambled single-port SRAM wrapper. On an
//   accepted init request it waits for a valid scrambling key, then walks every
//   word address and writes filler through the RAM req/gnt interface. Once the
//   walk completes, the RAM port becomes a transparent pass-through for the host.
//
//   Optional feature macro: SRAM_SCR_INIT_LFSR_EN
//     defined   : filler = 32-bit Galois LFSR state (x^32+x^22+x^2+x+1),
//                 replicated and truncated to Width
//     undefined : filler = all zeros; no LFSR and no Seed check
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   key_valid_i         scrambling key valid; gates the start of the walk
//   init_req_i          single-cycle (re)initialise request, accepted in IDLE
//   busy_o              high while waiting for the key or walking
//   init_done_o         high after a complete walk
//   host_*              host-side req/gnt port (write, addr, wdata, wmask, rdata, rvalid)
//   ram_*               RAM-side req/gnt port
module sram_scr_init #(
  parameter int unsigned Depth     = 16384,
  parameter int unsigned Width     = 32,
  parameter logic [31:0] Seed      = 32'h0000_0001,
  parameter int unsigned AddrWidth = (Depth == 1) ? 1 : $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 key_valid_i,
  input  logic                 init_req_i,
  output logic                 busy_o,
  output logic                 init_done_o,
  input  logic                 host_req_i,
  output logic                 host_gnt_o,
  input  logic                 host_write_i,
  input  logic [AddrWidth-1:0] host_addr_i,
  input  logic [Width-1:0]     host_wdata_i,
  input  logic [Width-1:0]     host_wmask_i,
  output logic [Width-1:0]     host_rdata_o,
  output logic                 host_rvalid_o,
  output logic                 ram_req_o,
  input  logic                 ram_gnt_i,
  output logic                 ram_write_o,
  output logic [AddrWidth-1:0] ram_addr_o,
  output logic [Width-1:0]     ram_wdata_o,
  output logic [Width-1:0]     ram_wmask_o,
  input  logic [Width-1:0]     ram_rdata_i,
  input  logic                 ram_rvalid_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_KEY = 2'd1,
    INIT     = 2'd2
  } state_e;

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 init_done_q, init_done_d;
  logic                 busy_q, busy_d;
  logic [Width-1:0]     filler;

`ifdef SRAM_SCR_INIT_LFSR_EN
  localparam logic [31:0] LfsrMask = 32'h8020_0003;
  localparam int unsigned Reps     = (Width + 31) / 32;

  if (Seed == 32'd0) begin : g_seed_zero
    $error("sram_scr_init: Seed must be non-zero");
  end

  logic [31:0]        lfsr_q, lfsr_d;
  logic [Reps*32-1:0] lfsr_rep;
  logic               lfsr_load;
  logic               lfsr_step;

  // Reload happens on the same condition that restarts the address counter,
  // and the LFSR steps exactly when a filler write is granted.
  assign lfsr_load = (state_q == IDLE) && init_req_i;
  assign lfsr_step = (state_q == INIT) && ram_gnt_i;

  always_comb begin
    lfsr_d = lfsr_q;
    if (lfsr_load) begin
      lfsr_d = Seed;
    end else if (lfsr_step) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrMask) : (lfsr_q >> 1);
    end
    lfsr_rep = {Reps{lfsr_q}};
    filler   = lfsr_rep[Width-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign filler = '0;
`endif

  // Next-state logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    init_done_d = init_done_q;
    unique case (state_q)
      IDLE: begin
        if (init_req_i) begin
          state_d     = WAIT_KEY;
          init_done_d = 1'b0;
          addr_d      = '0;
        end
      end
      WAIT_KEY: begin
        if (key_valid_i) begin
          state_d = INIT;
        end
      end
      INIT: begin
        if (ram_gnt_i) begin
          if (addr_q == LastAddr) begin
            addr_d      = '0;
            state_d     = IDLE;
            init_done_d = 1'b1;
          end else begin
            addr_d = addr_q + AddrWidth'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      init_done_q <= init_done_d;
      busy_q      <= busy_d;
    end
  end

  // Port steering: the host drives the RAM in IDLE (gated by init_done), the
  // walker drives it in INIT, and nothing is requested while waiting for a key.
  always_comb begin
    ram_req_o   = 1'b0;
    host_gnt_o  = 1'b0;
    ram_write_o = host_write_i;
    ram_addr_o  = host_addr_i;
    ram_wdata_o = host_wdata_i;
    ram_wmask_o = host_wmask_i;
    unique case (state_q)
      IDLE: begin
        ram_req_o  = host_req_i & init_done_q;
        host_gnt_o = ram_gnt_i & init_done_q;
      end
      INIT: begin
        ram_req_o   = 1'b1;
        ram_write_o = 1'b1;
        ram_addr_o  = addr_q;
        ram_wdata_o = filler;
        ram_wmask_o = '1;
      end
      default: begin
      end
    endcase
  end

  // The walker only writes, so every read response belongs to the host.
  assign host_rdata_o  = ram_rdata_i;
  assign host_rvalid_o = ram_rvalid_i;
  assign busy_o        = busy_q;
  assign init_done_o   = init_done_q;

endmodule
